// File: rtl/fb_spi_pkg.sv
// Shared constants, FSM state encoding and command decode for the SPI framebuffer writer.
package fb_spi_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic [7:0] CMD_PANEL1 = 8'h01;
  localparam logic [7:0] CMD_PANEL2 = 8'h02;
  localparam logic [7:0] CMD_BOTH   = 8'h03;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    HI   = 3'd3,
    LO   = 3'd4,
    DROP = 3'd5
  } state_t;

  // Bit 0 selects panel 1, bit 1 selects panel 2; zero means the command is ignored.
  function automatic logic [1:0] cmd_to_mask(input logic [7:0] cmd);
    logic [1:0] mask;
    case (cmd)
      CMD_PANEL1: mask = 2'b01;
      CMD_PANEL2: mask = 2'b10;
      CMD_BOTH:   mask = 2'b11;
      default:    mask = 2'b00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: pin synchronisers, edge detect, MSB-first shifter.
// Optional loopback shifter on MISO is built only when SPI_LOOPBACK_EN is defined.
module spi_byte_rx
  import fb_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       byte_vld,
  output logic [7:0] byte_q,
  output logic       cs_active,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic       sck_fall,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   sck_rise_q;
  logic [7:0]             shift;
  logic [2:0]             cnt;

  // CS is synchronised already inverted so a reset chain reads as "no transaction".
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync   <= '0;
      cs_sync    <= '0;
      mosi_sync  <= '0;
      sck_prev   <= 1'b0;
      cs_prev    <= 1'b0;
      sck_rise_q <= 1'b0;
      shift      <= 8'h00;
      cnt        <= 3'd0;
      byte_vld   <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], ~cs_n};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev   <= sck_sync[SYNC_STAGES-1];
      cs_prev    <= cs_sync[SYNC_STAGES-1];
      sck_rise_q <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
      byte_vld   <= 1'b0;
      if (!cs_sync[SYNC_STAGES-1]) begin
        cnt <= 3'd0;
      end else if (sck_rise_q) begin
        shift <= {shift[6:0], mosi_sync[SYNC_STAGES-1]};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_q   <= {shift[6:0], mosi_sync[SYNC_STAGES-1]};
        end
      end
    end
  end

  assign cs_active = cs_sync[SYNC_STAGES-1];
  assign cs_rise   = cs_prev & ~cs_sync[SYNC_STAGES-1];
  assign cs_fall   = ~cs_prev & cs_sync[SYNC_STAGES-1];
  assign sck_fall  = sck_prev & ~sck_sync[SYNC_STAGES-1];

`ifdef SPI_LOOPBACK_EN
  logic [7:0] lb_hold;
  logic [7:0] lb_shift;
  logic       lb_out;

  // The falling edge that closes a byte (counter wrapped to 0) starts the held byte on MISO.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_hold  <= 8'h00;
      lb_shift <= 8'h00;
      lb_out   <= 1'b0;
    end else if (!cs_sync[SYNC_STAGES-1]) begin
      lb_hold  <= 8'h00;
      lb_shift <= 8'h00;
      lb_out   <= 1'b0;
    end else begin
      if (sck_rise_q && (cnt == 3'd7)) begin
        lb_hold <= {shift[6:0], mosi_sync[SYNC_STAGES-1]};
      end
      if (sck_fall) begin
        if (cnt == 3'd0) begin
          lb_out   <= lb_hold[7];
          lb_shift <= {lb_hold[6:0], 1'b0};
        end else begin
          lb_out   <= lb_shift[7];
          lb_shift <= {lb_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign miso = lb_out;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: rtl/spi_framebuffer_writer.sv
// SPI slave that turns CMD/ADDR/{HI,LO} byte streams into single-cycle framebuffer RAM writes.
// Define SPI_LOOPBACK_EN to echo the previous received byte on o_spi_miso.
module spi_framebuffer_writer
  import fb_spi_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_sck,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic [ADDR_W-1:0] o_waddr_1,
  output logic [DATA_W-1:0] o_wdata_1,
  output logic              o_we_1,
  output logic [ADDR_W-1:0] o_waddr_2,
  output logic [DATA_W-1:0] o_wdata_2,
  output logic              o_we_2,
  output logic              o_busy
);

  logic              byte_vld;
  logic [7:0]        byte_q;
  logic              cs_active;
  logic              cs_rise;
  logic              cs_fall;
  logic              sck_fall;
  state_t            state;
  logic [1:0]        mask;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi_q;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk      (i_clk),
    .rst      (i_rst),
    .sck      (i_spi_sck),
    .cs_n     (i_spi_cs_n),
    .mosi     (i_spi_mosi),
    .byte_vld (byte_vld),
    .byte_q   (byte_q),
    .cs_active(cs_active),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .sck_fall (sck_fall),
    .miso     (o_spi_miso)
  );

  assign o_busy = cs_active;

  // Transaction FSM; end of chip select outranks a byte arriving in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      mask      <= 2'b00;
      addr      <= '0;
      hi_q      <= 8'h00;
      o_waddr_1 <= '0;
      o_wdata_1 <= '0;
      o_we_1    <= 1'b0;
      o_waddr_2 <= '0;
      o_wdata_2 <= '0;
      o_we_2    <= 1'b0;
    end else begin
      o_we_1 <= 1'b0;
      o_we_2 <= 1'b0;
      if (cs_rise) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (cs_fall) state <= CMD;
          CMD: if (byte_vld) begin
            mask  <= cmd_to_mask(byte_q);
            state <= (cmd_to_mask(byte_q) != 2'b00) ? ADDR : DROP;
          end
          ADDR: if (byte_vld) begin
            addr  <= ADDR_W'(byte_q);
            state <= HI;
          end
          HI: if (byte_vld) begin
            hi_q  <= byte_q;
            state <= LO;
          end
          LO: if (byte_vld) begin
            if (mask[0]) begin
              o_waddr_1 <= addr;
              o_wdata_1 <= DATA_W'({hi_q, byte_q});
              o_we_1    <= 1'b1;
            end
            if (mask[1]) begin
              o_waddr_2 <= addr;
              o_wdata_2 <= DATA_W'({hi_q, byte_q});
              o_we_2    <= 1'b1;
            end
            addr  <= addr + ADDR_W'(1);
            state <= HI;
          end
          DROP: state <= DROP;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_framebuffer_writer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random transactions.
module tb_spi_framebuffer_writer;

  localparam int S = 2;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst, sck, cs_n, mosi;
  logic        miso, we1, we2, busy;
  logic [7:0]  waddr1, waddr2;
  logic [15:0] wdata1, wdata2;

  spi_framebuffer_writer #(.ADDR_W(8), .DATA_W(16), .SYNC_STAGES(S)) dut (
    .i_clk(clk), .i_rst(rst), .i_spi_sck(sck), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi),
    .o_spi_miso(miso),
    .o_waddr_1(waddr1), .o_wdata_1(wdata1), .o_we_1(we1),
    .o_waddr_2(waddr2), .o_wdata_2(wdata2), .o_we_2(we2),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int last_rise = 0;
  int checks = 0;
  int fails = 0;
  logic prev_we1 = 1'b0;
  logic prev_we2 = 1'b0;
  logic [23:0] q1[$], q2[$], e1[$], e2[$];
  int c1[$], c2[$];
  logic [7:0] txn[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write capture plus strobe-width and pin-to-strobe latency checks.
  always @(negedge clk) begin
    if (we1) begin
      q1.push_back({waddr1, wdata1});
      c1.push_back(cyc);
      check("we1_one_cycle", 32'(prev_we1), 32'd0);
      check("we1_latency", 32'(cyc - last_rise), 32'(S + 3));
    end
    if (we2) begin
      q2.push_back({waddr2, wdata2});
      c2.push_back(cyc);
      check("we2_one_cycle", 32'(prev_we2), 32'd0);
      check("we2_latency", 32'(cyc - last_rise), 32'(S + 3));
    end
    prev_we1 <= we1;
    prev_we2 <= we2;
  end

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (H) @(negedge clk);
    sck = 1'b1;
    last_rise = cyc;
    m = miso;
    repeat (H) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], r[i]);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (3 * H) @(negedge clk);
  endtask

  // Sends the global txn bytes then pbits stray bits, inside one chip-select window.
  task automatic run_txn(input int pbits);
    logic [7:0] r;
    logic       m;
    cs_start();
    foreach (txn[i]) spi_byte(txn[i], r);
    for (int i = 0; i < pbits; i++) spi_bit(1'($urandom_range(0, 1)), m);
    cs_end();
  endtask

  // Reference: decode command, then one write per complete HI/LO pair at an incrementing address.
  task automatic model();
    logic [7:0] c;
    logic [7:0] a;
    logic [1:0] m;
    if (txn.size() < 2) return;
    c = txn[0];
    m = (c >= 8'd1 && c <= 8'd3) ? c[1:0] : 2'b00;
    a = txn[1];
    for (int i = 2; i + 1 < txn.size(); i += 2) begin
      if (m[0]) e1.push_back({a, txn[i], txn[i+1]});
      if (m[1]) e2.push_back({a, txn[i], txn[i+1]});
      a = a + 8'd1;
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_n1"}, 32'(q1.size()), 32'(e1.size()));
    check({tag, "_n2"}, 32'(q2.size()), 32'(e2.size()));
    for (int i = 0; i < e1.size() && i < q1.size(); i++) check({tag, "_w1"}, 32'(q1[i]), 32'(e1[i]));
    for (int i = 0; i < e2.size() && i < q2.size(); i++) check({tag, "_w2"}, 32'(q2[i]), 32'(e2[i]));
    if (e1.size() > 0 && e2.size() > 0 && e1.size() == e2.size())
      for (int i = 0; i < c1.size() && i < c2.size(); i++) check({tag, "_same_cycle"}, 32'(c1[i]), 32'(c2[i]));
    q1.delete(); q2.delete(); c1.delete(); c2.delete(); e1.delete(); e2.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_we"}, {30'd0, we1, we2}, 32'd0);
    check({tag, "_p1"}, {8'd0, waddr1, wdata1}, 32'd0);
    check({tag, "_p2"}, {8'd0, waddr2, wdata2}, 32'd0);
    check({tag, "_miso"}, 32'(miso), 32'd0);
  endtask

  typedef struct packed {
    logic [0:5][7:0]  b;
    logic [3:0]       nb;
    logic [3:0]       pbits;
    logic [3:0]       n1;
    logic [3:0]       n2;
    logic [0:1][7:0]  wa;
    logic [0:1][15:0] wd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] r0, r1, rb;
    logic       m;

    vecs[0] = '{b:{8'h01,8'h10,8'h12,8'h34,8'h56,8'h78}, nb:4'd6, pbits:4'd0, n1:4'd2, n2:4'd0,
                wa:{8'h10,8'h11}, wd:{16'h1234,16'h5678}};
    vecs[1] = '{b:{8'h03,8'hFF,8'hAB,8'hCD,8'h01,8'h02}, nb:4'd6, pbits:4'd0, n1:4'd2, n2:4'd2,
                wa:{8'hFF,8'h00}, wd:{16'hABCD,16'h0102}};
    vecs[2] = '{b:{8'h01,8'h20,8'h55,8'h00,8'h00,8'h00}, nb:4'd3, pbits:4'd0, n1:4'd0, n2:4'd0,
                wa:{8'h00,8'h00}, wd:{16'h0,16'h0}};
    vecs[3] = '{b:{8'h02,8'h05,8'h00,8'h01,8'h00,8'h00}, nb:4'd4, pbits:4'd0, n1:4'd0, n2:4'd1,
                wa:{8'h05,8'h00}, wd:{16'h0001,16'h0}};
    vecs[4] = '{b:{8'h7E,8'h11,8'h22,8'h33,8'h44,8'h00}, nb:4'd5, pbits:4'd0, n1:4'd0, n2:4'd0,
                wa:{8'h00,8'h00}, wd:{16'h0,16'h0}};
    vecs[5] = '{b:{8'h01,8'h40,8'hAA,8'hBB,8'h00,8'h00}, nb:4'd4, pbits:4'd5, n1:4'd1, n2:4'd0,
                wa:{8'h40,8'h00}, wd:{16'hAABB,16'h0}};
    vecs[6] = '{b:{8'h02,8'h00,8'h00,8'h00,8'h00,8'h00}, nb:4'd1, pbits:4'd3, n1:4'd0, n2:4'd0,
                wa:{8'h00,8'h00}, wd:{16'h0,16'h0}};
    vecs[7] = '{b:{8'h03,8'h33,8'h00,8'h00,8'h00,8'h00}, nb:4'd2, pbits:4'd0, n1:4'd0, n2:4'd0,
                wa:{8'h00,8'h00}, wd:{16'h0,16'h0}};

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      txn.delete();
      for (int i = 0; i < int'(vecs[v].nb); i++) txn.push_back(vecs[v].b[i]);
      run_txn(int'(vecs[v].pbits));
      for (int i = 0; i < int'(vecs[v].n1); i++) e1.push_back({vecs[v].wa[i], vecs[v].wd[i]});
      for (int i = 0; i < int'(vecs[v].n2); i++) e2.push_back({vecs[v].wa[i], vecs[v].wd[i]});
      compare_writes($sformatf("vec%0d", v));
    end

    // o_busy follows CS_n rise after exactly S clock edges.
    cs_start();
    spi_byte(8'h7E, rb);
    for (int i = 0; i < 4; i++) spi_byte(8'(i + 1), rb);
    repeat (H) @(negedge clk);
    check("busy_open", 32'(busy), 32'd1);
    cs_n = 1'b1;
    @(negedge clk);
    check("busy_after_1", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_S", 32'(busy), 32'd0);
    repeat (3 * H) @(negedge clk);
    compare_writes("drop_cmd");

    // MISO echo of the previous byte.
    cs_start();
    spi_byte(8'hA5, r0);
    spi_byte(8'h3C, r1);
    cs_end();
    check("miso_byte0", 32'(r0), 32'h00);
`ifdef SPI_LOOPBACK_EN
    check("miso_byte1", 32'(r1), 32'hA5);
`else
    check("miso_byte1", 32'(r1), 32'h00);
`endif
    compare_writes("loopback");

    // Reset in the middle of the first data byte drops the transaction.
    cs_start();
    spi_byte(8'h01, rb);
    spi_byte(8'h10, rb);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * H) @(negedge clk);
    compare_writes("midreset_nowrite");
    txn = '{8'h02, 8'h7F, 8'hBE, 8'hEF};
    run_txn(0);
    e2.push_back({8'h7F, 16'hBEEF});
    compare_writes("after_reset");

    // Random transactions against the reference model.
    for (int t = 0; t < 20; t++) begin
      int kind;
      int nd;
      txn.delete();
      kind = $urandom_range(0, 3);
      txn.push_back(kind == 0 ? 8'($urandom) : 8'(kind));
      txn.push_back(8'($urandom));
      nd = $urandom_range(0, 6);
      for (int i = 0; i < nd; i++) txn.push_back(8'($urandom));
      if ($urandom_range(0, 4) == 0) txn = txn[0:0];
      run_txn($urandom_range(0, 1) == 1 ? $urandom_range(1, 7) : 0);
      model();
      compare_writes($sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
